// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_pkg
// Description : Shared constants for the interrupt controller and the Bridge:
//               register offsets, source limit, bus widths, VEC field layout.
// Revision    : 1.0 - initial release
// ============================================================================
package irq_pkg;

    localparam int c_MAX_SRC = 6;
    localparam int c_ADDR_W  = 30;
    localparam int c_DATA_W  = 32;

    // Word offsets within the controller's DEV slot
    typedef enum logic [1:0] {
        REG_PEND = 2'd0,
        REG_MASK = 2'd1,
        REG_MODE = 2'd2,
        REG_VEC  = 2'd3
    } reg_off_t;

    // VEC register field positions
    localparam int c_VEC_VALID_BIT = 31;
    localparam int c_VEC_IDX_LSB   = 0;
    localparam int c_VEC_IDX_W     = 3;
    localparam int c_VEC_LAST_LSB  = 4;

endpackage
`default_nettype wire

// File: rtl/irq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctrl_if
// Description : Bridge-side register bus of the interrupt controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface irq_ctrl_if;
    import irq_pkg::*;

    logic [c_ADDR_W-1:0] addr;
    logic                we;
    logic [c_DATA_W-1:0] din;
    logic [c_DATA_W-1:0] dout;

    modport master (output addr, output we, output din, input  dout);
    modport slave  (input  addr, input  we, input  din, output dout);

endinterface
`default_nettype wire

// File: rtl/irq_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : irq_sync_edge
// Description : Per-source synchroniser chain plus history flop; provides the
//               synchronised level and a one-cycle rising-edge strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic src,
    output logic      lvl,
    output logic      rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    // Synchroniser shift chain and edge-detect history; history clears on reset
    // so a source already high at release is seen as one edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], src};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign lvl  = r_sync[SYNC_STAGES-1];
    assign rise = lvl & ~r_hist;

endmodule
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctrl
// Description : Memory-mapped interrupt controller. Synchronises, edge/level
//               qualifies, latches and masks up to 6 sources; presents
//               PEND&MASK to the CPU and a priority-encoded VEC register.
//               Optional macro IRQ_CTRL_ROUND_ROBIN_EN selects rotating
//               priority starting after the last acknowledged source.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int                     N_SRC       = 6,
    parameter int                     SYNC_STAGES = 2,
    parameter logic [c_MAX_SRC-1:0]   MODE_RST    = 6'b111111
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic [N_SRC-1:0] irq_src,
    irq_ctrl_if.slave             bus,
    output logic      [N_SRC-1:0] hw_int,
    output logic                  irq_any
);

    logic [N_SRC-1:0]    w_lvl;
    logic [N_SRC-1:0]    w_rise;
    logic [N_SRC-1:0]    w_clr;
    logic [N_SRC-1:0]    w_pend_nxt;
    logic [N_SRC-1:0]    r_pend;
    logic [N_SRC-1:0]    r_mask;
    logic [N_SRC-1:0]    r_mode;
    reg_off_t            w_off;
    logic                w_wr_pend;
    logic                w_wr_mask;
    logic                w_wr_mode;
    logic                w_wr_vec;
    logic [2:0]          w_ack_idx;
    logic                w_ack_ok;
    logic [2:0]          w_start;
    logic [2:0]          w_vec_idx;
    logic [c_DATA_W-1:0] w_dout;
    logic                w_unused_bits;

    generate
        for (genvar i = 0; i < N_SRC; i++) begin : g_src
            irq_sync_edge #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_sync (
                .clk   (clk),
                .reset (reset),
                .src   (irq_src[i]),
                .lvl   (w_lvl[i]),
                .rise  (w_rise[i])
            );
        end
    endgenerate

    assign w_off     = reg_off_t'(bus.addr[1:0]);
    assign w_wr_pend = bus.we && (w_off == REG_PEND);
    assign w_wr_mask = bus.we && (w_off == REG_MASK);
    assign w_wr_mode = bus.we && (w_off == REG_MODE);
    assign w_wr_vec  = bus.we && (w_off == REG_VEC);
    assign w_ack_idx = bus.din[2:0];
    assign w_ack_ok  = w_wr_vec && (int'(w_ack_idx) < N_SRC);

    // Only the word offset and the low data bits are meaningful here
    assign w_unused_bits = ^{bus.addr[c_ADDR_W-1:2], bus.din};

    // Clear requests: W1C on PEND plus a single-bit ack through VEC
    always_comb begin
        w_clr = '0;
        if (w_wr_pend) begin
            w_clr = bus.din[N_SRC-1:0];
        end
        for (int i = 0; i < N_SRC; i++) begin
            if (w_ack_ok && (w_ack_idx == 3'(i))) begin
                w_clr[i] = 1'b1;
            end
        end
    end

    // Edge bits: a new edge beats a same-cycle clear; level bits follow the line
    always_comb begin
        w_pend_nxt = '0;
        for (int i = 0; i < N_SRC; i++) begin
            w_pend_nxt[i] = r_mode[i] ? (w_rise[i] | (r_pend[i] & ~w_clr[i]))
                                      : w_lvl[i];
        end
    end

    // Pending, mask and mode registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend <= '0;
            r_mask <= '0;
            r_mode <= MODE_RST[N_SRC-1:0];
        end else begin
            r_pend <= w_pend_nxt;
            if (w_wr_mask) r_mask <= bus.din[N_SRC-1:0];
            if (w_wr_mode) r_mode <= bus.din[N_SRC-1:0];
        end
    end

    assign hw_int  = r_pend & r_mask;
    assign irq_any = |hw_int;

`ifdef IRQ_CTRL_ROUND_ROBIN_EN
    logic [2:0] r_last_acked;

    // Remember the most recent valid ack to rotate the search start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_acked <= 3'(N_SRC - 1);
        end else if (w_ack_ok) begin
            r_last_acked <= w_ack_idx;
        end
    end

    assign w_start = (r_last_acked >= 3'(N_SRC - 1)) ? 3'd0 : (r_last_acked + 3'd1);
`else
    assign w_start = 3'd0;
`endif

    // First requesting source found when scanning upward from start (wrapping)
    function automatic logic [2:0] f_prio(input logic [N_SRC-1:0] req,
                                          input logic [2:0]       start);
        logic [2:0] idx;
        logic [2:0] j;
        logic       found;
        idx   = 3'd0;
        found = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            j = 3'((int'(start) + i) % N_SRC);
            if (!found && req[j]) begin
                idx   = j;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    assign w_vec_idx = f_prio(hw_int, w_start);

    // Read mux; unused bits read zero
    always_comb begin
        w_dout = '0;
        case (w_off)
            REG_PEND: w_dout[N_SRC-1:0] = r_pend;
            REG_MASK: w_dout[N_SRC-1:0] = r_mask;
            REG_MODE: w_dout[N_SRC-1:0] = r_mode;
            REG_VEC: begin
                w_dout[c_VEC_VALID_BIT] = irq_any;
                w_dout[c_VEC_IDX_LSB +: c_VEC_IDX_W] = w_vec_idx;
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
                w_dout[c_VEC_LAST_LSB +: 3] = r_last_acked;
`endif
            end
            default: w_dout = '0;
        endcase
    end

    assign bus.dout = w_dout;

endmodule
`default_nettype wire

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Memory-mapped programmable interrupt controller between device IRQ lines (Timer0, Timer1, UART, future peripherals) and the CPU's 6-bit HWInt[7:2] input.
- Synchronises, edge/level-qualifies, latches and masks up to 6 sources.
- Presents a registered pending vector to the CPU and a priority-encoded vector register that software reads and acknowledges through the Bridge as one more DEV slot.

Parameters:
- N_SRC, 6, number of interrupt sources (1..6); unused HWInt bits tie to 0.
- SYNC_STAGES, 2, synchroniser flops per source (>=2).
- MODE_RST, 6'b111111, reset value of MODE (1 = edge, 0 = level).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- irq_src  input  N_SRC  raw device interrupt lines, active-high; bit 0 is highest fixed priority.
- addr  input  30  byte-address bits [31:2] from Bridge; only addr[1:0] (byte offset [3:2]) are decoded.
- we  input  1  write enable from Bridge, already qualified for this slot.
- din  input  32  write data.
- dout  output  32  read data, combinational from registers.
- hw_int  output  N_SRC  PEND & MASK, driven from registers, to the CPU HWInt.
- irq_any  output  1  OR of hw_int.

Behaviour:
- Register map (word offset):
  - 0 PEND: read returns pending bits; write is W1C on edge-mode bits and ignored on level bits.
  - 1 MASK: RW, reset 0.
  - 2 MODE: RW, reset MODE_RST.
  - 3 VEC: read returns {valid, 28'b0, idx[2:0]}, where idx is the highest-priority bit of PEND&MASK and valid = irq_any. Writing VEC with din[2:0]=k acks source k (clears PEND[k] if edge mode). k >= N_SRC is ignored.
- Unused dout bits read 0.
- Sync: irq_src passes through SYNC_STAGES flops, plus one history flop for edge detection.
- Edge mode: PEND[i] sets on a synced 0->1 transition.
  - If set and clear (W1C or VEC ack) hit the same bit in the same cycle, set wins.
- Level mode: PEND[i] <= synced level every cycle. Clear requests have no effect.
- MODE write:
  - Takes effect the next cycle.
  - Switching level->edge keeps the current PEND bit.
  - Switching edge->level overwrites it with the synced level.
- Latency, SYNC_STAGES=2: a source rising before edge N sets PEND at edge N+2; hw_int/irq_any are high in the cycle after edge N+2.
- MASK write takes effect on hw_int the cycle after the write edge. Masking never clears PEND.
- A source held high in edge mode produces exactly one PEND set.
- Reset, asynchronous and also mid-operation:
  - PEND, MASK, synchronisers and history flops clear to 0; MODE <= MODE_RST.
  - hw_int = 0, irq_any = 0, dout = 0 except MODE reads.
  - A source already high at reset release counts as an edge once it is synced (history flop is 0).
- Reads have no side effects.

Optional Feature:
- Macro IRQ_CTRL_ROUND_ROBIN_EN.
- Defined:
  - VEC idx uses rotating priority: search starts at (last_acked+1) mod N_SRC.
  - The last_acked register (reset N_SRC-1) updates on every valid VEC ack write.
  - Register offset 3 bits [6:4] read last_acked.
- Undefined: fixed priority, bit 0 highest; bits [6:4] read 0.

Decomposition:
- Shared package irq_pkg: register offsets (PEND/MASK/MODE/VEC), MAX_SRC=6, VEC field positions. The Bridge uses the same offset constants.
- One natural sub-module, irq_sync_edge: per-source synchroniser plus edge detector (params SYNC_STAGES; outputs lvl, rise). Instantiate it N_SRC times with a generate loop.
- The priority encoder stays inline as a function.

Test Plan:
- Edge basic: MASK=6'h03, pulse irq_src[1] for 1 cycle -> hw_int=6'h02 at N+3 cycle; VEC reads 32'h80000001; write VEC=1 -> hw_int=0, VEC=0.
- Simultaneous set/clear: PEND[0] set; W1C 0x1 in the same cycle as a new rising edge on src0 -> PEND[0] stays 1.
- Level mode: MODE=0, MASK=6'h3F, hold irq_src[2] high -> PEND=6'h04; W1C 0x04 -> still 6'h04; drop source -> PEND=0 after 2 cycles.
- Masking: irq_src[3] edge with MASK=0 -> PEND=6'h08, hw_int=0, VEC=0; write MASK=6'h08 -> hw_int=6'h08 next cycle.
- Priority: edges on src 4 and 1 together -> VEC idx=1. With IRQ_CTRL_ROUND_ROBIN_EN, after ack 1 and re-pending of 1 and 4 -> idx=4.
- Async reset mid-pending: assert reset between clock edges with PEND=6'h3F -> hw_int=0 immediately, MODE=6'h3F; src high at release -> PEND sets after 2 cycles.
